// File: rtl/gpa_fhdo_serial_iface.sv
// SPI master for the GPA-FHDO gradient board (DAC80504 + ADS8684 on one bus).
// Ports: clk, rst_n, data_i/valid_i command in, spi_clk_div_i, busy_o, fhd_* serial pins, adc_value_o.
module gpa_fhdo_serial_iface #(
  parameter int DAC_BITS = 24,
  parameter int ADC_BITS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_i,
  input  logic        valid_i,
  input  logic [5:0]  spi_clk_div_i,
  output logic        busy_o,
  output logic        fhd_clk_o,
  output logic        fhd_sdo_o,
  input  logic        fhd_sdi_i,
  output logic        fhd_csn_o,
  output logic [15:0] adc_value_o
);

  localparam logic [6:0] DAC_EDGES = 7'(2 * DAC_BITS);
  localparam logic [6:0] ADC_EDGES = 7'(2 * ADC_BITS);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    FRAME_RESET,
    SHIFT,
    CS_HOLD,
    DONE
  } state_t;

  state_t      state, state_nx;
  logic [5:0]  div_q;
  logic [5:0]  hcnt;
  logic [6:0]  ecnt;
  logic        is_adc;
  logic [31:0] shreg;
  logic [15:0] rx;
  logic        tick;
  logic        dac_op;
  logic        adc_op;
  logic        start;
  logic        last_edge;

  // channel tag and last-channel flag ride along without shaping the frame
  logic unused_tag;
  assign unused_tag = ^data_i[26:24];

  assign tick   = (hcnt == 6'd0);
  assign dac_op = (data_i[31:27] == 5'b00000);
  assign adc_op = (data_i[31:27] == 5'b01000);
  assign start  = valid_i & (dac_op | adc_op);

  assign last_edge = (ecnt == ((is_adc ? ADC_EDGES : DAC_EDGES) - 7'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = adc_op ? FRAME_RESET : CS_SETUP;
      end
      CS_SETUP: begin
        if (tick) state_nx = SHIFT;
      end
      FRAME_RESET: begin
        if (tick && ecnt == 7'd1) state_nx = SHIFT;
      end
      SHIFT: begin
        if (tick) begin
          if (is_adc && last_edge)
            state_nx = DONE;
          else if (!is_adc && ecnt == DAC_EDGES)
            state_nx = CS_HOLD;
        end
      end
      CS_HOLD: begin
        if (tick) state_nx = DONE;
      end
      DONE: begin
        if (tick) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      hcnt        <= '0;
      ecnt        <= '0;
      is_adc      <= 1'b0;
      shreg       <= '0;
      rx          <= '0;
      busy_o      <= 1'b0;
      fhd_clk_o   <= 1'b0;
      fhd_sdo_o   <= 1'b0;
      fhd_csn_o   <= 1'b1;
      adc_value_o <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        div_q     <= spi_clk_div_i;
        hcnt      <= spi_clk_div_i;
        ecnt      <= '0;
        is_adc    <= adc_op;
        shreg     <= {data_i[23:0], 8'h00};
        busy_o    <= 1'b1;
        // csn low: DAC select, or the ADC frame-reset pulse
        fhd_csn_o <= 1'b0;
        fhd_sdo_o <= adc_op ? 1'b0 : data_i[23];
      end
    end else if (!tick) begin
      hcnt <= hcnt - 6'd1;
    end else begin
      hcnt <= div_q;
      unique case (state)
        FRAME_RESET: begin
          if (ecnt == 7'd1) begin
            fhd_csn_o <= 1'b1;
            fhd_sdo_o <= shreg[31];
            ecnt      <= '0;
          end else begin
            ecnt <= ecnt + 7'd1;
          end
        end
        SHIFT: begin
          if (is_adc || ecnt != DAC_EDGES) begin
            fhd_clk_o <= ~fhd_clk_o;
            ecnt      <= ecnt + 7'd1;
            // DAC: next bit on rising edges (first bit already out)
            if (!is_adc && !fhd_clk_o && ecnt != 7'd0) begin
              shreg     <= {shreg[30:0], 1'b0};
              fhd_sdo_o <= shreg[30];
            end
            // ADC: sample on rising, next bit on falling
            if (is_adc && !fhd_clk_o)
              rx <= {rx[14:0], fhd_sdi_i};
            if (is_adc && fhd_clk_o) begin
              if (last_edge) begin
                fhd_sdo_o   <= 1'b0;
                adc_value_o <= rx;
              end else begin
                shreg     <= {shreg[30:0], 1'b0};
                fhd_sdo_o <= shreg[30];
              end
            end
          end
        end
        CS_HOLD: begin
          fhd_csn_o <= 1'b1;
          fhd_sdo_o <= 1'b0;
        end
        DONE: begin
          busy_o <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpa_fhdo_serial_iface.sv
// Directed bench for gpa_fhdo_serial_iface with DAC80504/ADS8684 bus models.
// Ports: drives command/divider/sdi, observes busy, SCLK, csn, sdo, adc_value.
module tb_gpa_fhdo_serial_iface;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data = '0;
  logic        valid = 1'b0;
  logic [5:0]  div = '0;
  logic        busy;
  logic        fhd_clk_o;
  logic        fhd_sdo_o;
  logic        sdi = 1'b0;
  logic        fhd_csn_o;
  logic [15:0] adc_value;

  int total = 0;
  int bad = 0;

  gpa_fhdo_serial_iface dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_i        (data),
    .valid_i       (valid),
    .spi_clk_div_i (div),
    .busy_o        (busy),
    .fhd_clk_o     (fhd_clk_o),
    .fhd_sdo_o     (fhd_sdo_o),
    .fhd_sdi_i     (sdi),
    .fhd_csn_o     (fhd_csn_o),
    .adc_value_o   (adc_value)
  );

  always #5 clk = ~clk;

  // bus models, evaluated between DUT edges
  logic        pclk = 1'b0;
  logic        pcsn = 1'b1;
  int          nb = 0;
  int          nf = 0;
  int          nr = 0;
  int          frames = 0;
  int          rises = 0;
  logic [23:0] dsh = '0;
  logic [23:0] last_frame = '0;
  logic [15:0] vout [4] = '{default: '0};
  logic [15:0] acmd = '0;
  logic [15:0] cur = '0;

  always @(negedge clk) begin
    pclk <= fhd_clk_o;
    pcsn <= fhd_csn_o;
    if (pcsn && !fhd_csn_o) begin
      nb <= 0;
    end else if (!pcsn && fhd_csn_o) begin
      if (nb == 24) begin
        frames     <= frames + 1;
        last_frame <= dsh;
        if (dsh[23:18] == 6'b000010)
          vout[dsh[17:16]] <= dsh[15:0];
      end
      // ADC answers with the conversion chosen in the previous frame
      if (nr == 32)
        cur <= vout[acmd[9:8]];
      nb  <= 0;
      nf  <= 0;
      nr  <= 0;
      sdi <= 1'b0;
    end else if (pclk && !fhd_clk_o) begin
      if (!fhd_csn_o) begin
        dsh <= {dsh[22:0], fhd_sdo_o};
        nb  <= nb + 1;
      end else begin
        nf  <= nf + 1;
        sdi <= (nf >= 15 && nf < 31) ? cur[30 - nf] : 1'b0;
      end
    end else if (!pclk && fhd_clk_o) begin
      rises <= rises + 1;
      if (fhd_csn_o) begin
        if (nr < 16)
          acmd <= {acmd[14:0], fhd_sdo_o};
        nr <= nr + 1;
      end
    end
  end

  function automatic logic [31:0] dac_cmd(input logic [7:0] r, input logic [15:0] v);
    return {8'h00, r, v};
  endfunction

  function automatic logic [31:0] adc_cmd(input logic [1:0] ch);
    return {8'h40, 6'b110000, ch, 16'h0000};
  endfunction

  task automatic send(input logic [31:0] d, input logic [5:0] dv);
    @(posedge clk); #1;
    data  = d;
    div   = dv;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL busy_timeout got busy=%0b want 0", busy);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
    total++;
    if (fhd_clk_o !== 1'b0) begin bad++; $display("FAIL rst_sclk got %b want 0", fhd_clk_o); end
    total++;
    if (fhd_csn_o !== 1'b1) begin bad++; $display("FAIL rst_csn got %b want 1", fhd_csn_o); end
    total++;
    if (fhd_sdo_o !== 1'b0) begin bad++; $display("FAIL rst_sdo got %b want 0", fhd_sdo_o); end
    total++;
    if (adc_value !== 16'h0000) begin bad++; $display("FAIL rst_adc got %h want 0000", adc_value); end
  endtask

  task automatic test_dac_single;
    int n;
    int r0;
    r0 = rises;
    send(32'h0008_0001, 6'd32);
    wait_idle(n);
    @(posedge clk); #1;
    total++;
    if (n != 1716) begin bad++; $display("FAIL dac_busy_len got %0d want 1716", n); end
    total++;
    if (rises - r0 != 24) begin bad++; $display("FAIL dac_pulses got %0d want 24", rises - r0); end
    total++;
    if (last_frame !== 24'h080001) begin bad++; $display("FAIL dac_frame got %h want 080001", last_frame); end
    total++;
    if (vout[0] !== 16'h0001) begin bad++; $display("FAIL dac_vout0 got %h want 0001", vout[0]); end
  endtask

  task automatic test_min_div;
    int n;
    send(dac_cmd(8'h09, 16'h0002), 6'd0);
    wait_idle(n);
    @(posedge clk); #1;
    total++;
    if (n != 52) begin bad++; $display("FAIL div0_busy_len got %0d want 52", n); end
    total++;
    if (vout[1] !== 16'h0002) begin bad++; $display("FAIL div0_vout1 got %h want 0002", vout[1]); end
  endtask

  task automatic test_four_channel(input logic [15:0] v0, input logic [15:0] v1,
                                   input logic [15:0] v2, input logic [15:0] v3);
    int n;
    logic [15:0] exp [4];
    exp = '{v0, v1, v2, v3};
    for (int i = 0; i < 4; i++) begin
      send(dac_cmd(8'(8 + i), exp[i]), 6'd2);
      wait_idle(n);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (vout[i] !== exp[i]) begin
        bad++;
        $display("FAIL four_ch_vout%0d got %h want %h", i, vout[i], exp[i]);
      end
    end
  endtask

  task automatic test_adc_reads;
    int n;
    logic [1:0]  chs [5];
    logic [15:0] exp [5];
    chs = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
    for (int i = 0; i < 5; i++) begin
      send(adc_cmd(chs[i]), 6'd2);
      wait_idle(n);
      total++;
      if (adc_value !== exp[i]) begin
        bad++;
        $display("FAIL adc_read%0d got %h want %h", i, adc_value, exp[i]);
      end
    end
  endtask

  task automatic test_adc_hold;
    total++;
    if (adc_value !== 16'h0004) begin
      bad++;
      $display("FAIL adc_hold got %h want 0004", adc_value);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int f0;
    logic [7:0] r;
    logic [15:0] v;
    f0 = frames;
    for (int i = 0; i < 8; i++) begin
      r = 8'(8 + (i % 4));
      v = 16'(10 + i);
      send(dac_cmd(r, v), 6'd1);
      wait_idle(n);
      total++;
      if (last_frame !== {r, v}) begin
        bad++;
        $display("FAIL b2b_frame%0d got %h want %h", i, last_frame, {r, v});
      end
    end
    @(posedge clk); #1;
    total++;
    if (frames - f0 != 8) begin bad++; $display("FAIL b2b_count got %0d want 8", frames - f0); end
    total++;
    if (vout[3] !== 16'h0011) begin bad++; $display("FAIL b2b_vout3 got %h want 0011", vout[3]); end
  endtask

  task automatic test_ignore_busy;
    int n;
    int f0;
    f0 = frames;
    send(dac_cmd(8'h09, 16'h1234), 6'd2);
    repeat (10) @(posedge clk);
    #1;
    data  = dac_cmd(8'h09, 16'hBEEF);
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    wait_idle(n);
    repeat (300) @(posedge clk);
    #1;
    total++;
    if (frames - f0 != 1) begin bad++; $display("FAIL busy_ignore_count got %0d want 1", frames - f0); end
    total++;
    if (vout[1] !== 16'h1234) begin bad++; $display("FAIL busy_ignore_vout1 got %h want 1234", vout[1]); end
  endtask

  task automatic test_illegal;
    int r0;
    r0 = rises;
    send(32'hF808_0001, 6'd0);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL illegal_busy got %b want 0", busy); end
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (rises != r0) begin bad++; $display("FAIL illegal_sclk got %0d want 0", rises - r0); end
    total++;
    if (fhd_csn_o !== 1'b1) begin bad++; $display("FAIL illegal_csn got %b want 1", fhd_csn_o); end
  endtask

  task automatic test_reset_mid;
    int n;
    int f0;
    f0 = frames;
    send(dac_cmd(8'h08, 16'h00AA), 6'd2);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (fhd_csn_o !== 1'b1) begin bad++; $display("FAIL midrst_csn got %b want 1", fhd_csn_o); end
    total++;
    if (fhd_clk_o !== 1'b0) begin bad++; $display("FAIL midrst_sclk got %b want 0", fhd_clk_o); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got %b want 0", busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(dac_cmd(8'h08, 16'h0055), 6'd2);
    wait_idle(n);
    @(posedge clk); #1;
    total++;
    if (vout[0] !== 16'h0055) begin bad++; $display("FAIL midrst_vout0 got %h want 0055", vout[0]); end
    total++;
    if (frames - f0 != 1) begin bad++; $display("FAIL midrst_count got %0d want 1", frames - f0); end
  endtask

  initial begin
    test_reset;
    test_dac_single;
    test_min_div;
    test_four_channel(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    test_adc_reads;
    test_four_channel(16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC);
    test_adc_hold;
    test_back_to_back;
    test_ignore_busy;
    test_illegal;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpa_fhdo_serial_iface.md
Name: gpa_fhdo_serial_iface

Overview:
- SPI master between the sequencer and the GPA-FHDO gradient board.
- One shared serial bus drives the DAC80504 4-channel DAC and the ADS8684 ADC.
- The board inverts chip select for the ADC.
- Takes one 32-bit command word per valid_i strobe, serialises it MSB-first, and returns the last ADC result on adc_value_o.

Parameters:
- DAC_BITS, 24, DAC frame length in SCLK cycles.
- ADC_BITS, 32, ADC frame length in SCLK cycles.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- data_i  in  32  command word.
- valid_i  in  1  one-cycle strobe; data_i is captured on the same cycle.
- spi_clk_div_i  in  6  SCLK divider.
- busy_o  out  1  high while a transaction is in progress.
- fhd_clk_o  out  1  SCLK; idles low.
- fhd_sdo_o  out  1  serial data to DAC and ADC.
- fhd_sdi_i  in  1  serial data from ADC.
- fhd_csn_o  out  1  chip select; low selects the DAC, high selects the ADC (board inverter); idles high.
- adc_value_o  out  16  last captured ADC word.

Behaviour:
- Reset values (async on rst_n low):
  - busy_o=0, fhd_clk_o=0, fhd_sdo_o=0, fhd_csn_o=1, adc_value_o=0.
  - State machine returns to IDLE; any frame in progress is aborted with csn high.
- Command decode:
  - data_i[31:27]=5'b00000: DAC write.
  - data_i[31:27]=5'b01000: ADC transaction.
  - Any other opcode: ignored, busy_o stays 0.
  - data_i[26:25] is the channel tag and data_i[24] the last-channel flag; both are carried but have no effect on serialisation.
  - data_i[23:0] is the payload.
- SCLK timing:
  - Half-period = spi_clk_div_i+1 clk cycles (div=32 gives 33 cycles, SCLK period 660 ns at 100 MHz).
  - The divider value is latched at transaction start.
- Handshake:
  - valid_i in IDLE captures data_i and asserts busy_o on the next clk edge.
  - valid_i while busy_o=1 is ignored, with no queuing.
- DAC write (states CS_SETUP, SHIFT, CS_HOLD):
  - fhd_csn_o falls and fhd_sdo_o presents payload[23] at the same edge.
  - After one half-period, 24 SCLK pulses follow.
  - fhd_sdo_o changes on SCLK rising edges so it is stable at falling edges (DAC latch).
  - After the 24th falling edge, wait one half-period, then raise fhd_csn_o.
  - busy_o drops one half-period after the csn rise.
- ADC transaction (states FRAME_RESET, SHIFT, DONE):
  - fhd_csn_o goes low for one SCLK period, which deasserts the ADC CS and ends any prior ADC frame. It then returns high to start the frame.
  - 32 SCLK pulses follow, shifting out {payload, 8'h00}.
  - In ADC frames, fhd_sdo_o changes on SCLK falling edges.
  - fhd_sdi_i is sampled on SCLK rising edges.
  - The last 16 sampled bits (bits 17-32 of the frame) are loaded into adc_value_o at frame end.
  - busy_o drops one half-period later.
  - The ADC returns the result of the previous command, so the first read after reset returns undefined/0.
- adc_value_o holds its value until the next ADC transaction completes. DAC writes never change it.
- Minimum case, div=0: half-period is 1 clk. A DAC transaction then has busy_o high for 1+1+48+1+1 cycles.
- ldacn is not driven; the DAC is used in synchronous-update mode.

Test Plan:
- Reset mid-transaction: assert rst_n low during a DAC frame -> csn=1, clk_o=0, busy_o=0 immediately; a new command is accepted after release.
- DAC write, div=32: data_i={5'd0,2'd0,1'd0,8'h08,16'h0001} -> 24 SCLK pulses, sdo shifts 0x080001 MSB-first; the DAC model vout0=1; busy_o high about 24*660 ns.
- Four-channel write 1,2,3,4 then -1,-2,-3,-4 with regs 0x08..0x0b -> DAC model vout0..3 show 0x0001..0x0004, then 0xFFFF..0xFFFC.
- ADC reads: commands 0xC00000, 0xC10000, 0xC20000, 0xC30000, 0xC00000 -> adc_value_o returns undefined/0, then ch0..ch3 codes matching the DAC outputs, each read one command late.
- Back-to-back: valid_i pulsed while busy_o=1 -> ignored; commands issued right after busy_o falls (0x08/a, 0x09/b, ... 0x0b/0x11) -> all eight frames appear with no loss or overlap.
- Illegal opcode 5'b11111 -> no SCLK activity, busy_o stays 0.
